pattern_ram: RTL and testbench
==============================

Name: pattern_ram

Overview:
- Shared 32-bit pattern memory that sits directly upstream of the function generator.
- The CPU fills it with DAC sample words over CaravelBus (Wishbone slave).
- The generator reads it over RAMBus (second Wishbone slave, 8-bit word address).
- Both ports share a single-port storage array; an arbiter gives RAMBus priority.

Parameters:
- BASE_ADDRESS, 32'h3000_0400, CaravelBus byte address of word 0; window is BASE_ADDRESS to BASE_ADDRESS+4*2**ADDR_W-1.
- ADDR_W, 8, word-address width; depth = 2**ADDR_W words; must be ≤ 8.

Ports:
- caravel_wb_clk_i, in, 1, single clock for both ports and the array.
- caravel_wb_rst_i, in, 1, synchronous active-high reset.
- caravel_wb_stb_i, in, 1, CaravelBus strobe.
- caravel_wb_cyc_i, in, 1, CaravelBus cycle.
- caravel_wb_we_i, in, 1, CaravelBus write enable.
- caravel_wb_sel_i, in, 4, CaravelBus byte lane select.
- caravel_wb_dat_i, in, 32, CaravelBus write data.
- caravel_wb_adr_i, in, 32, CaravelBus byte address.
- caravel_wb_ack_o, out, 1, CaravelBus ack.
- caravel_wb_dat_o, out, 32, CaravelBus read data.
- rambus_wb_stb_i, in, 1, RAMBus strobe (from generator).
- rambus_wb_cyc_i, in, 1, RAMBus cycle.
- rambus_wb_we_i, in, 1, RAMBus write enable.
- rambus_wb_sel_i, in, 4, RAMBus byte lane select.
- rambus_wb_dat_i, in, 32, RAMBus write data.
- rambus_wb_adr_i, in, 8, RAMBus word address; only bits [ADDR_W-1:0] are used.
- rambus_wb_ack_o, out, 1, RAMBus ack.
- rambus_wb_dat_o, out, 32, RAMBus read data.

Behaviour:
- Reset: caravel_wb_ack_o=0, rambus_wb_ack_o=0, caravel_wb_dat_o=0, rambus_wb_dat_o=0. Array contents are not reset and are undefined after power-up.
- Request detection:
  - RAMBus request pending: rb_req = rambus stb & cyc & !rambus_wb_ack_o.
  - CaravelBus request pending: cv_req = caravel stb & cyc & in_window & !caravel_wb_ack_o.
  - in_window: adr_i[31:2+ADDR_W] equals BASE_ADDRESS[31:2+ADDR_W]. The word index is adr_i[ADDR_W+1:2]; adr_i[1:0] is ignored.
  - The !ack term ensures a master that drops stb one cycle after seeing ack is never served twice.
- Arbitration, one array access per cycle:
  - If rb_req, RAMBus is granted.
  - Else if cv_req, CaravelBus is granted.
  - The ungranted request stays pending and is not acked.
- Granted access:
  - Write: each byte lane i with sel_i[i]=1 is written with dat_i[8i+7:8i] at the clock edge; lanes with sel=0 are unchanged.
  - Read: the array word is registered into that port's dat_o.
  - Ack: that port's ack_o goes high the cycle after the grant, for exactly one cycle.
  - Read latency is 1 cycle from stb sampled to ack and data valid.
- dat_o holds its last read value until the next granted read on that port. Writes leave dat_o unchanged.
- Out-of-window CaravelBus access: no ack, no array effect, dat_o unchanged. Other slaves on that bus respond instead.
- Same-address collision in one cycle: RAMBus completes first. CaravelBus is served the following cycle and sees or overwrites RAMBus's result (read-after-write ordering is by grant order).
- CaravelBus waits at most 1 extra cycle, because RAMBus cannot be granted in two consecutive cycles. Worst-case CaravelBus latency from request to ack is 2 cycles.
- Reset mid-transaction: acks clear the next edge. A pending request is dropped; the master must re-issue it. An array write granted in the same cycle reset is asserted is suppressed.

Optional Feature:
- Macro: PATTERN_RAM_STATS_EN.
- When defined, adds a status register at CaravelBus address BASE_ADDRESS+4*2**ADDR_W (just past the array):
  - [31:16]: RAMBus read count.
  - [15:0]: CaravelBus stall cycles, i.e. cycles with cv_req=1 while RAMBus is granted.
  - Both counters are 16-bit, saturate at 16'hFFFF, and reset to 0.
  - A read returns {rb_reads, cv_stalls} with normal 1-cycle ack.
  - A write of any data clears both counters and is acked.
  - The status register is arbitrated like the array but never stalled.
- When undefined, that address is out of window: no ack, no logic.

Test Plan:
- Reset, then CaravelBus write 32'hDEAD_BEEF to BASE_ADDRESS+8, then RAMBus read adr 2 -> rambus_wb_ack_o pulses 1 cycle after stb; rambus_wb_dat_o=32'hDEAD_BEEF.
- Word 5 holds 32'h1122_3344; CaravelBus write sel=4'b0101, dat=32'hAABB_CCDD to word 5, then read it back -> 32'h11BB_33DD.
- CaravelBus read word 3 and RAMBus read word 7 asserted in the same cycle -> RAMBus acked cycle+1; CaravelBus acked cycle+2; each port returns its own word.
- RAMBus master holds stb for 2 cycles after ack (generator timing), read adr 0 -> exactly one ack; no second access.
- CaravelBus access to BASE_ADDRESS+4*256 and 32'h3000_0000 with the macro undefined -> no ack within 8 cycles; array unchanged.
- With PATTERN_RAM_STATS_EN: perform 3 RAMBus reads, one of them colliding with a CaravelBus write -> status reads 32'h0003_0001; write to status, then read -> 32'h0000_0000.

Source files
------------

// File: rtl/pattern_ram.sv
// pattern_ram: shared 32-bit pattern memory feeding the function generator.
//
// The CPU fills the array over CaravelBus (Wishbone slave, byte addressed,
// window at BASE_ADDRESS). The generator reads it over RAMBus (Wishbone
// slave, word addressed). Both ports share one single-port array, so an
// arbiter grants one access per cycle, with RAMBus taking priority.
//
// Optional build macro: PATTERN_RAM_STATS_EN
//   Adds a status register just past the array on CaravelBus holding
//   {RAMBus read count, CaravelBus stall cycles}. Writing it clears both.
module pattern_ram #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0400,
  parameter int          ADDR_W       = 8
) (
  input  logic        caravel_wb_clk_i,
  input  logic        caravel_wb_rst_i,
  input  logic        caravel_wb_stb_i,
  input  logic        caravel_wb_cyc_i,
  input  logic        caravel_wb_we_i,
  input  logic [3:0]  caravel_wb_sel_i,
  input  logic [31:0] caravel_wb_dat_i,
  input  logic [31:0] caravel_wb_adr_i,
  output logic        caravel_wb_ack_o,
  output logic [31:0] caravel_wb_dat_o,
  input  logic        rambus_wb_stb_i,
  input  logic        rambus_wb_cyc_i,
  input  logic        rambus_wb_we_i,
  input  logic [3:0]  rambus_wb_sel_i,
  input  logic [31:0] rambus_wb_dat_i,
  input  logic [7:0]  rambus_wb_adr_i,
  output logic        rambus_wb_ack_o,
  output logic [31:0] rambus_wb_dat_o
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int TAG_LO = ADDR_W + 2;

  // Shared storage; intentionally not reset, contents undefined at power-up.
  logic [31:0] mem [DEPTH];

  // Address decode. adr[1:0] is ignored; the tag above the word index must
  // match the base so other slaves on CaravelBus keep their own windows.
  logic              in_window;
  logic [ADDR_W-1:0] cv_idx;
  logic [ADDR_W-1:0] rb_idx;

  assign in_window = (caravel_wb_adr_i[31:TAG_LO] == BASE_ADDRESS[31:TAG_LO]);
  assign cv_idx    = caravel_wb_adr_i[ADDR_W+1:2];
  assign rb_idx    = rambus_wb_adr_i[ADDR_W-1:0];

  // A request is only pending while its ack is low, so a master that is
  // still holding stb during its ack cycle is not served a second time.
  // This also means RAMBus can never win two cycles back to back, which
  // bounds the CaravelBus wait to a single extra cycle.
  logic rb_req;
  logic cv_req;
  logic rb_grant;
  logic cv_grant;

  assign rb_req = rambus_wb_stb_i & rambus_wb_cyc_i & ~rambus_wb_ack_o;
  assign cv_req = caravel_wb_stb_i & caravel_wb_cyc_i & in_window & ~caravel_wb_ack_o;

  // Fixed-priority arbiter: RAMBus first, CaravelBus only when RAMBus is idle.
  always_comb begin
    rb_grant = 1'b0;
    cv_grant = 1'b0;
    if (rb_req) begin
      rb_grant = 1'b1;
    end else if (cv_req) begin
      cv_grant = 1'b1;
    end
  end

  // Steer the granted port onto the single array write port.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [3:0]        wr_sel;
  logic [31:0]       wr_dat;

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    wr_sel = '0;
    wr_dat = '0;
    if (rb_grant) begin
      wr_en  = rambus_wb_we_i;
      wr_idx = rb_idx;
      wr_sel = rambus_wb_sel_i;
      wr_dat = rambus_wb_dat_i;
    end else if (cv_grant) begin
      wr_en  = caravel_wb_we_i;
      wr_idx = cv_idx;
      wr_sel = caravel_wb_sel_i;
      wr_dat = caravel_wb_dat_i;
    end
  end

  // Byte-lane array write; a write granted while reset is high is dropped.
  always_ff @(posedge caravel_wb_clk_i) begin
    if (!caravel_wb_rst_i && wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_sel[i]) begin
          mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
        end
      end
    end
  end

`ifdef PATTERN_RAM_STATS_EN
  // Status register sits one word past the array. It is a plain register,
  // not part of the array, so it never has to wait for RAMBus.
  localparam logic [31:0] STAT_ADDRESS = BASE_ADDRESS + 32'(4 * DEPTH);

  logic        stat_hit;
  logic        stat_req;
  logic        stat_grant;
  logic [15:0] rb_reads;
  logic [15:0] cv_stalls;
  logic [31:0] stat_word;

  assign stat_hit   = (caravel_wb_adr_i[31:2] == STAT_ADDRESS[31:2]);
  assign stat_req   = caravel_wb_stb_i & caravel_wb_cyc_i & stat_hit & ~caravel_wb_ack_o;
  assign stat_grant = stat_req;
  assign stat_word  = {rb_reads, cv_stalls};

  // Saturating activity counters; a status write clears both.
  always_ff @(posedge caravel_wb_clk_i) begin
    if (caravel_wb_rst_i) begin
      rb_reads  <= '0;
      cv_stalls <= '0;
    end else if (stat_grant && caravel_wb_we_i) begin
      rb_reads  <= '0;
      cv_stalls <= '0;
    end else begin
      if (rb_grant && !rambus_wb_we_i && rb_reads != 16'hFFFF) begin
        rb_reads <= rb_reads + 16'd1;
      end
      if (cv_req && rb_grant && cv_stalls != 16'hFFFF) begin
        cv_stalls <= cv_stalls + 16'd1;
      end
    end
  end
`else
  logic        stat_grant;
  logic [31:0] stat_word;

  assign stat_grant = 1'b0;
  assign stat_word  = '0;
`endif

  // RAMBus response: one-cycle ack after the grant, read data registered.
  always_ff @(posedge caravel_wb_clk_i) begin
    if (caravel_wb_rst_i) begin
      rambus_wb_ack_o <= 1'b0;
      rambus_wb_dat_o <= '0;
    end else begin
      rambus_wb_ack_o <= rb_grant;
      if (rb_grant && !rambus_wb_we_i) begin
        rambus_wb_dat_o <= mem[rb_idx];
      end
    end
  end

  // CaravelBus response: array or status read data, one-cycle ack.
  always_ff @(posedge caravel_wb_clk_i) begin
    if (caravel_wb_rst_i) begin
      caravel_wb_ack_o <= 1'b0;
      caravel_wb_dat_o <= '0;
    end else begin
      caravel_wb_ack_o <= cv_grant | stat_grant;
      if (cv_grant && !caravel_wb_we_i) begin
        caravel_wb_dat_o <= mem[cv_idx];
      end else if (stat_grant && !caravel_wb_we_i) begin
        caravel_wb_dat_o <= stat_word;
      end
    end
  end

  // Byte-offset bits and any RAMBus address bits above ADDR_W are don't-care.
  logic unused_ok;
  assign unused_ok = &{1'b0, caravel_wb_adr_i[1:0], rambus_wb_adr_i};

endmodule

// File: tb/tb_pattern_ram.sv
// tb_pattern_ram: self-checking bench for pattern_ram.
// Table of sequential transactions plus hand sequences for collisions,
// held strobes, out-of-window accesses and reset mid-transaction.
// Expected read data is queued per port when a request is driven and
// compared by a monitor when that port acks.
module tb_pattern_ram;

  logic        clk;
  logic        reset;
  logic        cv_stb, cv_cyc, cv_we;
  logic [3:0]  cv_sel;
  logic [31:0] cv_dat_i, cv_adr;
  logic        cv_ack;
  logic [31:0] cv_dat_o;
  logic        rb_stb, rb_cyc, rb_we;
  logic [3:0]  rb_sel;
  logic [31:0] rb_dat_i;
  logic [7:0]  rb_adr;
  logic        rb_ack;
  logic [31:0] rb_dat_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        is_read;
    logic [31:0] dat;
  } exp_t;

  exp_t cv_q[$];
  exp_t rb_q[$];
  exp_t cv_e, rb_e;
  vec_t vecs[18];

  pattern_ram dut (
    .caravel_wb_clk_i (clk),
    .caravel_wb_rst_i (reset),
    .caravel_wb_stb_i (cv_stb),
    .caravel_wb_cyc_i (cv_cyc),
    .caravel_wb_we_i  (cv_we),
    .caravel_wb_sel_i (cv_sel),
    .caravel_wb_dat_i (cv_dat_i),
    .caravel_wb_adr_i (cv_adr),
    .caravel_wb_ack_o (cv_ack),
    .caravel_wb_dat_o (cv_dat_o),
    .rambus_wb_stb_i  (rb_stb),
    .rambus_wb_cyc_i  (rb_cyc),
    .rambus_wb_we_i   (rb_we),
    .rambus_wb_sel_i  (rb_sel),
    .rambus_wb_dat_i  (rb_dat_i),
    .rambus_wb_adr_i  (rb_adr),
    .rambus_wb_ack_o  (rb_ack),
    .rambus_wb_dat_o  (rb_dat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic is_rb, input logic we, input logic [31:0] exp);
    exp_t e;
    e.is_read = ~we;
    e.dat     = exp;
    if (is_rb) rb_q.push_back(e);
    else       cv_q.push_back(e);
  endtask

  // Monitors: every ack must match a queued expectation.
  always @(negedge clk) begin
    if (rb_ack) begin
      if (rb_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL rb_unexpected_ack: got ack with no request queued");
      end else begin
        rb_e = rb_q.pop_front();
        if (rb_e.is_read) checkOutput("rb_read_data", rb_dat_o, rb_e.dat);
      end
    end
    if (cv_ack) begin
      if (cv_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL cv_unexpected_ack: got ack with no request queued");
      end else begin
        cv_e = cv_q.pop_front();
        if (cv_e.is_read) checkOutput("cv_read_data", cv_dat_o, cv_e.dat);
      end
    end
  end

  // One uncontended transaction; called and returns at posedge+1.
  task automatic applyStimulus(input vec_t v);
    int n;
    pushExp(v.rb, v.we, v.exp);
    if (v.rb) begin
      rb_stb = 1'b1; rb_cyc = 1'b1; rb_we = v.we;
      rb_sel = v.sel; rb_dat_i = v.dat; rb_adr = v.adr[7:0];
    end else begin
      cv_stb = 1'b1; cv_cyc = 1'b1; cv_we = v.we;
      cv_sel = v.sel; cv_dat_i = v.dat; cv_adr = v.adr;
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(v.rb ? rb_ack : cv_ack) && n < 8);
    rb_stb = 1'b0; rb_cyc = 1'b0;
    cv_stb = 1'b0; cv_cyc = 1'b0;
    checkOutput(v.rb ? "rb_latency" : "cv_latency", 32'(n), 32'd1);
    @(posedge clk); #1;
  endtask

  // Both ports request in the same cycle; RAMBus must ack first.
  task automatic collide(input logic cv_w, input logic [31:0] c_adr, input logic [31:0] c_dat,
                         input logic [31:0] c_exp, input logic rb_w, input logic [7:0] r_adr,
                         input logic [31:0] r_dat, input logic [31:0] r_exp);
    int rb_n, cv_n;
    pushExp(1'b0, cv_w, c_exp);
    pushExp(1'b1, rb_w, r_exp);
    cv_stb = 1'b1; cv_cyc = 1'b1; cv_we = cv_w; cv_sel = 4'hF; cv_dat_i = c_dat; cv_adr = c_adr;
    rb_stb = 1'b1; rb_cyc = 1'b1; rb_we = rb_w; rb_sel = 4'hF; rb_dat_i = r_dat; rb_adr = r_adr;
    rb_n = 0;
    cv_n = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (rb_ack && rb_n == 0) begin rb_n = c; rb_stb = 1'b0; rb_cyc = 1'b0; end
      if (cv_ack && cv_n == 0) begin cv_n = c; cv_stb = 1'b0; cv_cyc = 1'b0; end
      if (rb_n != 0 && cv_n != 0) break;
    end
    rb_stb = 1'b0; rb_cyc = 1'b0; cv_stb = 1'b0; cv_cyc = 1'b0;
    checkOutput("collide_rb_ack_cycle", 32'(rb_n), 32'd1);
    checkOutput("collide_cv_ack_cycle", 32'(cv_n), 32'd2);
    @(posedge clk); #1;
  endtask

  // CaravelBus access outside the window must never be acked.
  task automatic oowAccess(input logic [31:0] adr, input logic we);
    int acks;
    acks = 0;
    cv_stb = 1'b1; cv_cyc = 1'b1; cv_we = we; cv_sel = 4'hF; cv_dat_i = 32'hBAD0_BAD0; cv_adr = adr;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (cv_ack) acks++;
    end
    cv_stb = 1'b0; cv_cyc = 1'b0;
    checkOutput("oow_no_ack", 32'(acks), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    int acks;

    vecs[0]  = '{1'b0, 1'b1, 32'h3000_0408, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'd2,         4'hF, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h3000_0414, 4'hF, 32'h1122_3344, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h3000_0414, 4'h5, 32'hAABB_CCDD, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h3000_0414, 4'hF, 32'h0,         32'h11BB_33DD};
    vecs[5]  = '{1'b1, 1'b1, 32'd3,         4'hF, 32'h0303_0303, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 32'd7,         4'hF, 32'h0707_0707, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'h3000_07FC, 4'hF, 32'hCAFE_F00D, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'd255,       4'hF, 32'h0,         32'hCAFE_F00D};
    vecs[9]  = '{1'b0, 1'b0, 32'h3000_040F, 4'hF, 32'h0,         32'h0303_0303};
    vecs[10] = '{1'b0, 1'b1, 32'h3000_0400, 4'hF, 32'h0000_0000, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 32'd0,         4'hA, 32'h1234_5678, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h3000_0400, 4'hF, 32'h0,         32'h1200_5600};
    vecs[13] = '{1'b1, 1'b0, 32'd5,         4'hF, 32'h0,         32'h11BB_33DD};
    vecs[14] = '{1'b0, 1'b1, 32'h3000_0408, 4'h2, 32'h0000_AA00, 32'h0};
    vecs[15] = '{1'b1, 1'b0, 32'd2,         4'hF, 32'h0,         32'hDEAD_AAEF};
    vecs[16] = '{1'b0, 1'b1, 32'h3000_0410, 4'hF, 32'h4444_4444, 32'h0};
    vecs[17] = '{1'b0, 1'b0, 32'h3000_0410, 4'hF, 32'h0,         32'h4444_4444};

    reset = 1'b1;
    cv_stb = 1'b0; cv_cyc = 1'b0; cv_we = 1'b0; cv_sel = '0; cv_dat_i = '0; cv_adr = '0;
    rb_stb = 1'b0; rb_cyc = 1'b0; rb_we = 1'b0; rb_sel = '0; rb_dat_i = '0; rb_adr = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cv_ack", 32'(cv_ack), 32'd0);
    checkOutput("reset_rb_ack", 32'(rb_ack), 32'd0);
    checkOutput("reset_cv_dat", cv_dat_o, 32'h0);
    checkOutput("reset_rb_dat", rb_dat_o, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] table-driven transactions");
    for (int i = 0; i < 18; i++) applyStimulus(vecs[i]);

    $display("[TB] collision on different words");
    collide(1'b0, 32'h3000_040C, 32'h0, 32'h0303_0303, 1'b0, 8'd7, 32'h0, 32'h0707_0707);

    $display("[TB] RAMBus strobe held through ack");
    pushExp(1'b1, 1'b0, 32'h1200_5600);
    rb_stb = 1'b1; rb_cyc = 1'b1; rb_we = 1'b0; rb_sel = 4'hF; rb_adr = 8'd0;
    acks = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (rb_ack) acks++;
      if (c == 2) begin rb_stb = 1'b0; rb_cyc = 1'b0; end
    end
    checkOutput("rb_hold_single_ack", 32'(acks), 32'd1);

    $display("[TB] out-of-window CaravelBus accesses");
    oowAccess(32'h3000_0000, 1'b1);
    oowAccess(32'h3000_0C00, 1'b1);
`ifndef PATTERN_RAM_STATS_EN
    oowAccess(32'h3000_0800, 1'b1);
`endif
    oowAccess(32'h3000_0000, 1'b0);
    checkOutput("oow_cv_dat_held", cv_dat_o, 32'h0303_0303);
    v = '{1'b1, 1'b0, 32'd0, 4'hF, 32'h0, 32'h1200_5600};
    applyStimulus(v);

    $display("[TB] same-word collisions");
    collide(1'b1, 32'h3000_041C, 32'h7777_7777, 32'h0, 1'b0, 8'd7, 32'h0, 32'h0707_0707);
    v = '{1'b0, 1'b0, 32'h3000_041C, 4'hF, 32'h0, 32'h7777_7777};
    applyStimulus(v);
    collide(1'b0, 32'h3000_040C, 32'h0, 32'h3333_3333, 1'b1, 8'd3, 32'h3333_3333, 32'h0);

    $display("[TB] reset during a granted write");
    cv_stb = 1'b1; cv_cyc = 1'b1; cv_we = 1'b1; cv_sel = 4'hF;
    cv_dat_i = 32'h5555_5555; cv_adr = 32'h3000_0410;
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_mid_cv_ack", 32'(cv_ack), 32'd0);
    checkOutput("rst_mid_cv_dat", cv_dat_o, 32'h0);
    checkOutput("rst_mid_rb_dat", rb_dat_o, 32'h0);
    reset = 1'b0; cv_stb = 1'b0; cv_cyc = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_after_cv_ack", 32'(cv_ack), 32'd0);
    v = '{1'b0, 1'b0, 32'h3000_0410, 4'hF, 32'h0, 32'h4444_4444};
    applyStimulus(v);

`ifdef PATTERN_RAM_STATS_EN
    $display("[TB] status register");
    v = '{1'b0, 1'b1, 32'h3000_0800, 4'hF, 32'h0, 32'h0};
    applyStimulus(v);
    v = '{1'b1, 1'b0, 32'd2, 4'hF, 32'h0, 32'hDEAD_AAEF};
    applyStimulus(v);
    v = '{1'b1, 1'b0, 32'd5, 4'hF, 32'h0, 32'h11BB_33DD};
    applyStimulus(v);
    collide(1'b1, 32'h3000_0418, 32'h6666_6666, 32'h0, 1'b0, 8'd7, 32'h0, 32'h7777_7777);
    v = '{1'b0, 1'b0, 32'h3000_0800, 4'hF, 32'h0, 32'h0003_0001};
    applyStimulus(v);
    v = '{1'b0, 1'b1, 32'h3000_0800, 4'hF, 32'hFFFF_FFFF, 32'h0};
    applyStimulus(v);
    v = '{1'b0, 1'b0, 32'h3000_0800, 4'hF, 32'h0, 32'h0000_0000};
    applyStimulus(v);
`endif

    repeat (2) @(posedge clk);
    #1;
    checkOutput("cv_queue_drained", 32'(cv_q.size()), 32'd0);
    checkOutput("rb_queue_drained", 32'(rb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
